// File: rtl/even_parity_pkg.sv
// Shared types and default link constants for the even-parity serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a; the transmit side imports the same constants so both ends agree.
package even_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DATA_W_DEF       = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; a plain level follower.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages load the reset value so an idle-high line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/even_parity_serial_rx.sv
// Even-parity serial receiver: start, DATA_W bits LSB first, parity, stop; counts parity errors.
// Latency: rx_valid pulses (2+DATA_W)*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after start detection.
// Backpressure: none; results are held until the next frame completes and overwrites them.
module even_parity_serial_rx
    import even_parity_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ERR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W + 1);

    // Start bit is checked at its middle; every later bit is taken one full bit period on.
    localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCNT_W-1:0] FULL_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    logic              rxs;
    rx_state_t         state, state_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par_bit, par_nxt;
    logic              done;
    logic              perr_new;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // Data XOR parity bit must be 0 for a good even-parity frame.
    assign perr_new = (^shift) ^ par_bit;
    assign busy     = (state != IDLE);

    // Next-state, bit timing and data capture for the frame walker.
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt + BCNT_W'(1);
        idx_nxt   = idx;
        shift_nxt = shift;
        par_nxt   = par_bit;
        done      = 1'b0;
        case (state)
            IDLE: begin
                bcnt_nxt = '0;
                if (!rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bcnt == HALF_LAST) begin
                    bcnt_nxt  = '0;
                    idx_nxt   = '0;
                    // A line back high at mid start bit was a glitch, not a frame.
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bcnt == FULL_LAST) begin
                    bcnt_nxt = '0;
                    for (int i = 0; i < DATA_W; i++) begin
                        if (idx == IDX_W'(i)) begin
                            shift_nxt[i] = rxs;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state_nxt = PARITY;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bcnt == FULL_LAST) begin
                    bcnt_nxt  = '0;
                    par_nxt   = rxs;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bcnt == FULL_LAST) begin
                    bcnt_nxt  = '0;
                    done      = 1'b1;
                    // Back to IDLE regardless of line level; a low line here starts the next frame.
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
            end
        endcase
    end

    // Frame walker state; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcnt    <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            bcnt    <= bcnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            par_bit <= par_nxt;
        end
    end

    // Publish results at the stop sample; framing errors still report data and parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            rx_valid <= done;
            if (done) begin
                rx_data    <= shift;
                parity_err <= perr_new;
                frame_err  <= ~rxs;
                if (perr_new && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Bench for even_parity_serial_rx: directed and random frames against a frame-level model.
// Latency: checks the full start-detect to rx_valid span and the one-cycle pulse.
// Backpressure: n/a; the line is driven open-loop one bit period at a time.
module tb_even_parity_serial_rx;
    import even_parity_pkg::*;

    localparam int DW  = DATA_W_DEF;
    localparam int CPB = CLKS_PER_BIT_DEF;
    localparam int SPAN = (2 + DW) * CPB + CPB / 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;
    logic sel2 = 1'b0;
    logic rxd1, rxd2;

    assign rxd1 = sel2 ? 1'b1 : line;
    assign rxd2 = sel2 ? line : 1'b1;

    logic [DW-1:0] rx_data1, rx_data2;
    logic          rx_valid1, rx_valid2;
    logic          parity_err1, parity_err2;
    logic          frame_err1, frame_err2;
    logic          busy1, busy2;
    logic [7:0]    err_cnt1;
    logic [1:0]    err_cnt2;

    even_parity_serial_rx dut1 (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd1),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid1),
        .parity_err (parity_err1),
        .frame_err  (frame_err1),
        .busy       (busy1),
        .err_cnt    (err_cnt1)
    );

    even_parity_serial_rx #(.ERR_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd2),
        .rx_data    (rx_data2),
        .rx_valid   (rx_valid2),
        .parity_err (parity_err2),
        .frame_err  (frame_err2),
        .busy       (busy2),
        .err_cnt    (err_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic [7:0] cnt;
        logic       busy;
        int         run;
    } rec_t;

    rec_t q1[$];
    rec_t q2[$];
    int   run1 = 0, run2 = 0, vlong = 0;
    logic pv1 = 1'b0, pv2 = 1'b0;
    int   n_assert = 0, n_fail = 0;
    int   mcnt1 = 0, mcnt2 = 0;

    // Record every rx_valid with the length of the busy stretch that led up to it.
    always @(negedge clk) begin
        rec_t r;
        if (rx_valid1) begin
            r.data = rx_data1; r.perr = parity_err1; r.ferr = frame_err1;
            r.cnt = err_cnt1; r.busy = busy1; r.run = run1;
            q1.push_back(r);
            run1 = 0;
        end else if (busy1) run1++;
        else run1 = 0;
        if (rx_valid2) begin
            r.data = rx_data2; r.perr = parity_err2; r.ferr = frame_err2;
            r.cnt = {6'b0, err_cnt2}; r.busy = busy2; r.run = run2;
            q2.push_back(r);
            run2 = 0;
        end else if (busy2) run2++;
        else run2 = 0;
        if ((rx_valid1 && pv1) || (rx_valid2 && pv2)) vlong++;
        pv1 = rx_valid1;
        pv2 = rx_valid2;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive start, data LSB first, parity and stop; each level held one bit period.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            line = bits[i];
            repeat (CPB) @(negedge clk);
        end
        line = 1'b1;
    endtask

    // Model: parity error when data plus parity bit has odd weight; counter saturates.
    task automatic check_frame(input string tag, input int which,
                               input logic [7:0] d, input logic p, input logic s);
        rec_t r;
        int   perr, cnt, sz;
        perr = ($countones(d) + int'(p)) % 2;
        if (which == 1) begin
            mcnt1 = (mcnt1 + perr > 255) ? 255 : mcnt1 + perr;
            cnt = mcnt1;
        end else begin
            mcnt2 = (mcnt2 + perr > 3) ? 3 : mcnt2 + perr;
            cnt = mcnt2;
        end
        for (int k = 0; k < 60; k++) begin
            sz = (which == 1) ? q1.size() : q2.size();
            if (sz != 0) break;
            @(negedge clk);
        end
        sz = (which == 1) ? q1.size() : q2.size();
        chk({tag, " valid_count"}, sz, 1);
        if (sz == 0) return;
        r = (which == 1) ? q1.pop_front() : q2.pop_front();
        if (which == 1) q1.delete(); else q2.delete();
        chk({tag, " rx_data"}, r.data, d);
        chk({tag, " parity_err"}, r.perr, perr);
        chk({tag, " frame_err"}, r.ferr, !s);
        chk({tag, " err_cnt"}, r.cnt, cnt);
        chk({tag, " busy_at_valid"}, r.busy, 0);
        chk({tag, " span"}, r.run, SPAN);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp, rs;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rx_data", rx_data1, 0);
        chk("reset rx_valid", rx_valid1, 0);
        chk("reset parity_err", parity_err1, 0);
        chk("reset frame_err", frame_err1, 0);
        chk("reset busy", busy1, 0);
        chk("reset err_cnt", err_cnt1, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b1);
        check_frame("a5_good", 1, 8'hA5, 1'b0, 1'b1);
        repeat (10) @(negedge clk);

        send_frame(8'h07, 1'b0, 1'b1);
        check_frame("07_badpar", 1, 8'h07, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1);
        check_frame("07_goodpar", 1, 8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);

        send_frame(8'h3C, 1'b0, 1'b0);
        check_frame("3c_framerr", 1, 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        // Short low glitch: must be rejected at mid start bit.
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        @(negedge clk);
        chk("glitch busy_seen", busy1, 1);
        repeat (7) @(negedge clk);
        chk("glitch busy_cleared", busy1, 0);
        repeat (10) @(negedge clk);
        chk("glitch no_valid", q1.size(), 0);
        chk("glitch data_held", rx_data1, 8'h3C);
        chk("glitch ferr_held", frame_err1, 1);

        send_frame(8'h55, 1'b0, 1'b1);
        check_frame("55_after_glitch", 1, 8'h55, 1'b0, 1'b1);
        repeat (10) @(negedge clk);

        // Partial frame, then a one-cycle reset while in the data bits.
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
        repeat (40) @(negedge clk);
        chk("midreset busy_before", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mcnt1 = 0;
        chk("midreset rx_data", rx_data1, 0);
        chk("midreset rx_valid", rx_valid1, 0);
        chk("midreset parity_err", parity_err1, 0);
        chk("midreset frame_err", frame_err1, 0);
        chk("midreset busy", busy1, 0);
        chk("midreset err_cnt", err_cnt1, 0);
        repeat (200) @(negedge clk);
        chk("midreset no_valid", q1.size(), 0);

        // Back-to-back pair with no idle gap.
        send_frame(8'h01, 1'b1, 1'b1);
        check_frame("b2b_01", 1, 8'h01, 1'b1, 1'b1);
        send_frame(8'hFE, 1'b1, 1'b1);
        check_frame("b2b_fe", 1, 8'hFE, 1'b1, 1'b1);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs);
            check_frame("random", 1, rd, rp, rs);
            repeat (20) @(negedge clk);
        end

        // Narrow counter on the second instance must saturate.
        sel2 = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = ~(^rd);
            send_frame(rd, rp, 1'b1);
            check_frame("sat", 2, rd, rp, 1'b1);
            repeat (10) @(negedge clk);
        end
        chk("sat final_cnt", err_cnt2, 3);
        chk("dut1 quiet during sat", q1.size(), 0);
        chk("valid pulse width", vlong, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/even_parity_serial_rx.md
# even_parity_serial_rx

Serial receiver and checker for even-parity frames: start bit, DATA_W data bits LSB first, one even-parity bit, one stop bit. It recovers the data word, checks parity and framing, and counts parity errors. It is the receive end of the even-parity link: the transmit side appends P = XOR of the data bits; this block verifies that the XOR of the data bits and P is 0.

## Interface
- DATA_W, 8, data bits per frame; legal range 1..32.
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, at least 4.
- ERR_W, 8, width of the saturating parity-error counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_W  last received data word.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity result of the last frame; 1 = XOR of data and parity bit is 1.
- frame_err  out  1  1 = last frame's stop bit was sampled as 0.
- busy  out  1  high while the FSM is outside IDLE.
- err_cnt  out  ERR_W  count of frames with parity_err = 1; saturates at all-ones.

## Operation
- rxd passes through a 2-flop synchronizer. Both flops reset to 1. The FSM uses only the synchronized value rxs.
- A bit counter bcnt (width clog2(CLKS_PER_BIT)) and a data-bit index idx (width clog2(DATA_W+1)) drive the FSM.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxs == 0, go to START with bcnt = 0.
- START: when bcnt == CLKS_PER_BIT/2-1, sample rxs (mid-bit).
  - rxs == 0: go to DATA with bcnt = 0 and idx = 0.
  - rxs == 1: false start; go to IDLE with no output change.
- DATA: when bcnt == CLKS_PER_BIT-1, shift rxs into shift-register bit idx (LSB first) and reset bcnt. After the DATA_W-th bit, go to PARITY.
- PARITY: when bcnt == CLKS_PER_BIT-1, capture par_bit and go to STOP.
- STOP: when bcnt == CLKS_PER_BIT-1, do all of the following on the same edge, then go to IDLE:
  - rx_data <= shift register.
  - parity_err <= (^shift) ^ par_bit.
  - frame_err <= ~rxs.
  - rx_valid <= 1.
  - err_cnt increments if the new parity_err is 1 and err_cnt is not all-ones.
- A frame with frame_err = 1 still reports data and parity and still pulses rx_valid.
- A new start bit is accepted from IDLE on the cycle after STOP completes. The FSM does not wait for the line to return high.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0, err_cnt = 0, FSM = IDLE, sync flops = 1.
- rst is synchronous and overrides everything, including mid-frame. A partial frame is discarded with no rx_valid.
- Input latency: a falling edge on rxd is visible to the FSM 2 cycles later.
- Sampling point: data, parity and stop bits are sampled CLKS_PER_BIT/2 cycles after each bit's nominal start, measured at the synchronized line.
- rx_valid rises 1 cycle after the STOP sample edge and lasts exactly 1 cycle.
- rx_data, parity_err and frame_err hold until the next rx_valid.
- busy is 1 from the cycle after IDLE detects the low level through the cycle the FSM is in STOP. busy is 0 in the rx_valid cycle.
- A frame spans (2+DATA_W)·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles from start detection to rx_valid. With defaults this is 168 cycles.

## Structure
- Shared package even_parity_pkg:
  - FSM state enum: rx_state_t with IDLE, START, DATA, PARITY, STOP.
  - Default constants: DATA_W_DEF = 8, CLKS_PER_BIT_DEF = 16. The transmit side uses the same constants so both ends agree.
- Sub-module sync_2ff: 2-flop synchronizer with a reset value parameter, set to 1 here.
- Parity is a single XOR reduction with no sub-module. The FSM, counters and error counter live in the top module.

## Test plan
- Defaults; send 0xA5 (four ones) with parity 0 and stop 1.
  - Required: rx_valid for one cycle, rx_data = 0xA5, parity_err = 0, frame_err = 0, err_cnt = 0.
- Send 0x07 with a wrong parity bit of 0.
  - Required: parity_err = 1 and err_cnt = 1.
  - Then send 0x07 with parity 1: parity_err = 0 and err_cnt stays 1.
- Send 0x3C with correct parity and stop bit 0.
  - Required: frame_err = 1, parity_err = 0, rx_valid still pulses, rx_data = 0x3C.
- Drive rxd low for 4 cycles, then high.
  - Required: FSM returns to IDLE, no rx_valid, busy low again by cycle 12.
  - Then send frame 0x55: received correctly.
- Assert rst for 1 cycle in the middle of the DATA state.
  - Required: every output is at its reset value on the next cycle and no rx_valid occurs.
  - Then send a back-to-back pair 0x01 / 0xFE with no idle gap: both are received with parity_err = 0.
- Set ERR_W = 2 and send 5 frames with bad parity.
  - Required: err_cnt reads 1, 2, 3, 3, 3.
